// File: rtl/stopwatch_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_defs_pkg
//  Description : Shared stopwatch definitions: FSM state encodings, BCD
//                digit maxima and field positions inside the 16-bit MM:SS word.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_defs_pkg;

    // Stopwatch control states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RUN_LAP = 2'd2,
        ST_PAUSE   = 2'd3
    } sw_state_t;

    // Largest value of a units digit and of a tens digit (seconds/minutes)
    localparam logic [3:0] C_ONES_MAX = 4'd9;
    localparam logic [3:0] C_TENS_MAX = 4'd5;

    // Bit positions of each BCD digit in {min_tens, min_ones, sec_tens, sec_ones}
    localparam int C_SEC_ONES_LSB = 0;
    localparam int C_SEC_TENS_LSB = 4;
    localparam int C_MIN_ONES_LSB = 8;
    localparam int C_MIN_TENS_LSB = 12;

endpackage
`default_nettype wire

// File: rtl/bcd_mmss_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mmss_counter
//  Description : Chained BCD MM:SS counter, 00:00..59:59 with silent wrap.
//                clr has priority over inc.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mmss_counter
    import stopwatch_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] bcd
);

    logic [3:0] r_sec_ones;
    logic [3:0] r_sec_tens;
    logic [3:0] r_min_ones;
    logic [3:0] r_min_tens;

    logic w_so_max;
    logic w_st_max;
    logic w_mo_max;
    logic w_mt_max;

    assign w_so_max = (r_sec_ones == C_ONES_MAX);
    assign w_st_max = (r_sec_tens == C_TENS_MAX);
    assign w_mo_max = (r_min_ones == C_ONES_MAX);
    assign w_mt_max = (r_min_tens == C_TENS_MAX);

    // Each digit advances only when every lower digit sits at its maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
        end else if (clr) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
        end else if (inc) begin
            r_sec_ones <= w_so_max ? 4'd0 : r_sec_ones + 4'd1;
            if (w_so_max) begin
                r_sec_tens <= w_st_max ? 4'd0 : r_sec_tens + 4'd1;
            end
            if (w_so_max && w_st_max) begin
                r_min_ones <= w_mo_max ? 4'd0 : r_min_ones + 4'd1;
            end
            if (w_so_max && w_st_max && w_mo_max) begin
                r_min_tens <= w_mt_max ? 4'd0 : r_min_tens + 4'd1;
            end
        end
    end

    assign bcd[C_SEC_ONES_LSB +: 4] = r_sec_ones;
    assign bcd[C_SEC_TENS_LSB +: 4] = r_sec_tens;
    assign bcd[C_MIN_ONES_LSB +: 4] = r_min_ones;
    assign bcd[C_MIN_TENS_LSB +: 4] = r_min_tens;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Stopwatch sequencer: run/pause/lap FSM, 1 Hz prescaler,
//                lap snapshot register and display select.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_defs_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_pulse,
    input  logic        lap_pulse,
    output logic [15:0] live_bcd,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_active
);

    localparam int                    C_PRESC_W   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(CLK_HZ - 1);

    sw_state_t              r_state;
    sw_state_t              w_state_next;
    logic [C_PRESC_W-1:0]   r_presc;
    logic [15:0]            r_snapshot;

    logic w_lap_eff;
    logic w_counting;
    logic w_tick;
    logic w_clear_all;
    logic w_take_snap;

    // start wins when both buttons fire together
    assign w_lap_eff   = lap_pulse & ~start_pulse;
    // Increment decisions look only at the state before the edge
    assign w_counting  = (r_state == ST_RUN) || (r_state == ST_RUN_LAP);
    assign w_tick      = w_counting && (r_presc == C_PRESC_MAX);
    assign w_clear_all = (r_state == ST_IDLE) || ((r_state == ST_PAUSE) && w_lap_eff);
    assign w_take_snap = (r_state == ST_RUN) && w_lap_eff;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode from the two button pulses
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_pulse) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (start_pulse)    w_state_next = ST_PAUSE;
                else if (lap_pulse) w_state_next = ST_RUN_LAP;
            end
            ST_RUN_LAP: begin
                if (start_pulse)    w_state_next = ST_PAUSE;
                else if (lap_pulse) w_state_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (start_pulse)    w_state_next = ST_RUN;
                else if (lap_pulse) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Prescaler: counts while running, holds in pause, zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_clear_all) begin
            r_presc <= '0;
        end else if (w_counting) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    // Lap snapshot captures the pre-increment live value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snapshot <= 16'h0000;
        end else if (w_take_snap) begin
            r_snapshot <= live_bcd;
        end
    end

    bcd_mmss_counter u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clear_all),
        .inc   (w_tick),
        .bcd   (live_bcd)
    );

    assign running    = (r_state == ST_RUN) || (r_state == ST_RUN_LAP);
    assign lap_active = (r_state == ST_RUN_LAP);
    assign disp_bcd   = lap_active ? r_snapshot : live_bcd;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Self-checking bench for stopwatch_ctrl against a
//                seconds-based behavioural model (CLK_HZ = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int CLK_HZ = 4;

    logic        clk;
    logic        rst_n;
    logic        start_pulse;
    logic        lap_pulse;
    logic [15:0] live_bcd;
    logic [15:0] disp_bcd;
    logic        running;
    logic        lap_active;

    int n_checks = 0;
    int n_pass   = 0;

    typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE} m_mode_t;
    m_mode_t m_mode;
    int      m_secs;
    int      m_presc;
    int      m_snap;

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_pulse (start_pulse),
        .lap_pulse   (lap_pulse),
        .live_bcd    (live_bcd),
        .disp_bcd    (disp_bcd),
        .running     (running),
        .lap_active  (lap_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Seconds count to {min_tens, min_ones, sec_tens, sec_ones}
    function automatic logic [15:0] to_bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_secs  = 0;
        m_presc = 0;
        m_snap  = 0;
    endtask

    // One clock edge of the stopwatch rules, decided on the pre-edge mode
    task automatic model_step(input logic s, input logic l);
        bit counting;
        bit tick;
        counting = (m_mode == M_RUN) || (m_mode == M_LAP);
        tick     = counting && (m_presc == CLK_HZ - 1);
        if (m_mode == M_RUN && l && !s) m_snap = m_secs;
        if (counting) m_presc = tick ? 0 : m_presc + 1;
        else if (m_mode == M_IDLE) m_presc = 0;
        if (tick) m_secs = (m_secs + 1) % 3600;
        if (m_mode == M_PAUSE && l && !s) begin
            m_secs  = 0;
            m_presc = 0;
        end
        if (s) begin
            case (m_mode)
                M_IDLE, M_PAUSE: m_mode = M_RUN;
                default:         m_mode = M_PAUSE;
            endcase
        end else if (l) begin
            case (m_mode)
                M_RUN:   m_mode = M_LAP;
                M_LAP:   m_mode = M_RUN;
                M_PAUSE: m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        check("live_bcd",   32'(live_bcd),   32'(to_bcd(m_secs)));
        check("disp_bcd",   32'(disp_bcd),   32'(m_mode == M_LAP ? to_bcd(m_snap) : to_bcd(m_secs)));
        check("running",    32'(running),    32'(m_mode == M_RUN || m_mode == M_LAP));
        check("lap_active", 32'(lap_active), 32'(m_mode == M_LAP));
    endtask

    task automatic cycle(input logic s, input logic l);
        start_pulse = s;
        lap_pulse   = l;
        model_step(s, l);
        @(posedge clk);
        #1;
        start_pulse = 1'b0;
        lap_pulse   = 1'b0;
        compare_all();
    endtask

    // Idle cycles until the model reaches the target (presc < 0 means any)
    task automatic run_until(input string tag, input int secs, input int presc);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (m_secs == secs && (presc < 0 || m_presc == presc)) begin
                hit = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_live", 32'(live_bcd), 32'h0);
        check("rst_disp", 32'(disp_bcd), 32'h0);
        check("rst_run",  32'(running), 32'h0);
        check("rst_lap",  32'(lap_active), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] frozen;
        logic        s;
        logic        l;
        rst_n       = 1'b0;
        start_pulse = 1'b0;
        lap_pulse   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_live", 32'(live_bcd), 32'h0);
        check("reset_run",  32'(running), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start, first increments after 4 and 8 cycles
        cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0);
        check("first_sec", 32'(live_bcd), 32'h0001);
        repeat (4) cycle(1'b0, 1'b0);
        check("second_sec", 32'(live_bcd), 32'h0002);
        check("running_on", 32'(running), 32'h1);

        // Lap at 00:07, display holds while live continues
        run_until("reach_07", 7, -1);
        cycle(1'b0, 1'b1);
        check("lap_hold", 32'(disp_bcd), 32'h0007);
        run_until("reach_09", 9, -1);
        check("lap_live09", 32'(live_bcd), 32'h0009);
        check("lap_disp07", 32'(disp_bcd), 32'h0007);
        check("lap_flag",   32'(lap_active), 32'h1);
        cycle(1'b0, 1'b1);
        check("lap_release", 32'(disp_bcd), 32'h0009);

        // Seconds-to-minutes carry
        run_until("reach_59", 59, CLK_HZ - 1);
        cycle(1'b0, 1'b0);
        check("carry_min", 32'(live_bcd), 32'h0100);

        // Pause with prescaler at 2, frozen, resume, then clear via lap
        run_until("presc_2", 61, 2);
        cycle(1'b1, 1'b0);
        frozen = live_bcd;
        repeat (20) cycle(1'b0, 1'b0);
        check("pause_frozen", 32'(live_bcd), 32'(frozen));
        cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        check("pause_clear", 32'(live_bcd), 32'h0000);

        // Full wrap 59:59 -> 00:00
        cycle(1'b1, 1'b0);
        run_until("reach_5959", 3599, CLK_HZ - 1);
        check("at_5959", 32'(live_bcd), 32'h5959);
        cycle(1'b0, 1'b0);
        check("wrap", 32'(live_bcd), 32'h0000);

        // Lap coincident with tick at 00:03
        run_until("reach_03", 3, CLK_HZ - 1);
        cycle(1'b0, 1'b1);
        check("tick_lap_snap", 32'(disp_bcd), 32'h0003);
        check("tick_lap_live", 32'(live_bcd), 32'h0004);

        // Both buttons in RUN_LAP and RUN: start wins
        cycle(1'b1, 1'b1);
        check("both_pause", 32'(running), 32'h0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("both_nolap", 32'(lap_active), 32'h0);

        // Reset mid-second in RUN_LAP at 00:12
        cycle(1'b1, 1'b0);
        run_until("reach_12", 12, 1);
        cycle(1'b0, 1'b1);
        async_reset();
        cycle(1'b0, 1'b1);
        check("idle_after_rst", 32'(running), 32'h0);

        // Randomized button traffic with occasional asynchronous reset
        for (int i = 0; i < 6000; i++) begin
            s = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 7) == 0);
            cycle(s, l);
            if ($urandom_range(0, 1499) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
